// File: rtl/loproc_normalizer32_if.sv
// Request/result bundle for the 32-bit leading/trailing-zero normalizer.
// Handshake: start is sampled only while busy=0; done pulses for one cycle and results hold until the next accept.
interface loproc_normalizer32_if;
    logic        start;
    logic        tz_mode;
    logic [31:0] in_data;
    logic        busy;
    logic        done;
    logic [31:0] norm_out;
    logic [5:0]  zcount;
    logic        zero_flag;

    modport master (
        output start, tz_mode, in_data,
        input  busy, done, norm_out, zcount, zero_flag
    );

    modport slave (
        input  start, tz_mode, in_data,
        output busy, done, norm_out, zcount, zero_flag
    );
endinterface

// File: rtl/loproc_normalizer32.sv
// Multi-cycle CLZ/CTZ normalizer: coarse 4-bit steps, then fine 1-bit steps,
// returning the zero count and the word shifted so its MSB (or LSB) is set.
module loproc_normalizer32 #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    loproc_normalizer32_if.slave  bus,
    output logic [1:0]            dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_COARSE = 2'd1,
        S_FINE   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(DATA_WIDTH);

    state_t                  state_q;
    logic [DATA_WIDTH-1:0]   shreg_q;
    logic [CNT_WIDTH-1:0]    cnt_q;
    logic                    mode_q;
    logic                    busy_q;
    logic                    done_q;
    logic [DATA_WIDTH-1:0]   norm_q;
    logic [CNT_WIDTH-1:0]    zcount_q;
    logic                    zero_q;

    logic [3:0]              test_nibble;
    logic                    test_bit;
    logic [DATA_WIDTH-1:0]   shreg_sh4_d;
    logic [DATA_WIDTH-1:0]   shreg_sh1_d;
    logic [CNT_WIDTH-1:0]    cnt_p4_d;
    logic [CNT_WIDTH-1:0]    cnt_p1_d;

    // The "test end" is the MSB side in leading-zero mode and the LSB side in trailing-zero mode.
    always_comb begin
        test_nibble = mode_q ? shreg_q[3:0] : shreg_q[DATA_WIDTH-1 -: 4];
        test_bit    = mode_q ? shreg_q[0]   : shreg_q[DATA_WIDTH-1];
        shreg_sh4_d = mode_q ? (shreg_q >> 4) : (shreg_q << 4);
        shreg_sh1_d = mode_q ? (shreg_q >> 1) : (shreg_q << 1);
        cnt_p4_d    = cnt_q + CNT_WIDTH'(4);
        cnt_p1_d    = cnt_q + CNT_WIDTH'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            shreg_q  <= '0;
            cnt_q    <= '0;
            mode_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            norm_q   <= '0;
            zcount_q <= '0;
            zero_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        shreg_q <= bus.in_data;
                        cnt_q   <= '0;
                        mode_q  <= bus.tz_mode;
                        busy_q  <= 1'b1;
                        state_q <= S_COARSE;
                    end
                end

                S_COARSE: begin
                    // The cnt guard ends an all-zero word after eight nibble steps.
                    if (cnt_q == CNT_FULL) begin
                        done_q   <= 1'b1;
                        norm_q   <= shreg_q;
                        zcount_q <= cnt_q;
                        zero_q   <= 1'b1;
                        state_q  <= S_DONE;
                    end else if (test_nibble == 4'd0) begin
                        shreg_q <= shreg_sh4_d;
                        cnt_q   <= cnt_p4_d;
                    end else begin
                        state_q <= S_FINE;
                    end
                end

                S_FINE: begin
                    if (test_bit || (cnt_q == CNT_FULL)) begin
                        done_q   <= 1'b1;
                        norm_q   <= shreg_q;
                        zcount_q <= cnt_q;
                        zero_q   <= (cnt_q == CNT_FULL);
                        state_q  <= S_DONE;
                    end else begin
                        shreg_q <= shreg_sh1_d;
                        cnt_q   <= cnt_p1_d;
                    end
                end

                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end

                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.norm_out  = norm_q;
    assign bus.zcount    = zcount_q;
    assign bus.zero_flag = zero_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_loproc_normalizer32.sv
// Bench for loproc_normalizer32: directed vectors, a zero-count model and a per-cycle output checker.
module tb_loproc_normalizer32;

    typedef struct {
        logic [31:0] norm;
        logic [5:0]  z;
        logic        zf;
        int          lat;
        longint      start_cyc;
        longint      done_cyc;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [1:0]  dbg_state;
    longint      cyc;
    int          checks;
    int          errors;
    exp_t        exp_q[$];
    logic [31:0] hold_norm;
    logic [5:0]  hold_z;
    logic        hold_zf;

    loproc_normalizer32_if bus ();

    loproc_normalizer32 dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Model: scan from the selected end for the first set bit; latency is
    // one accept cycle, one step per nibble/bit, one final check, one DONE cycle.
    function automatic exp_t model(input logic mode, input logic [31:0] d);
        exp_t e;
        int   n;
        n = 0;
        while (n < 32 && (mode ? d[n] : d[31 - n]) == 1'b0) n++;
        e.z    = 6'(n);
        e.zf   = (n == 32);
        e.norm = mode ? (d >> n) : (d << n);
        e.lat  = (n == 32) ? 10 : 3 + (n / 4) + (n % 4);
        e.start_cyc = 0;
        e.done_cyc  = 0;
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Scoreboard / per-cycle compare
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("reset_outputs",
                {31'd0, bus.busy, bus.done, bus.norm_out, bus.zcount, bus.zero_flag},
                64'd0);
            exp_q.delete();
            hold_norm = '0;
            hold_z    = '0;
            hold_zf   = 1'b0;
        end else begin
            chk("busy", 64'(bus.busy),
                64'((exp_q.size() > 0) && (cyc >= exp_q[0].start_cyc + 1)));
            if (bus.done) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_done", 64'(bus.done), 64'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("done_cycle", 64'(cyc - e.start_cyc), 64'(e.lat));
                    chk("norm_out", 64'(bus.norm_out), 64'(e.norm));
                    chk("zcount", 64'(bus.zcount), 64'(e.z));
                    chk("zero_flag", 64'(bus.zero_flag), 64'(e.zf));
                    hold_norm = e.norm;
                    hold_z    = e.z;
                    hold_zf   = e.zf;
                end
            end else begin
                chk("held_results", {25'd0, bus.norm_out, bus.zcount, bus.zero_flag},
                    {25'd0, hold_norm, hold_z, hold_zf});
                if (exp_q.size() > 0 && cyc > exp_q[0].done_cyc) begin
                    chk("late_done", 64'(bus.done), 64'd1);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    // Drivers
    task automatic run_op(input logic mode, input logic [31:0] d);
        exp_t e;
        @(negedge clk); #1;
        e = model(mode, d);
        e.start_cyc = cyc;
        e.done_cyc  = cyc + e.lat;
        exp_q.push_back(e);
        bus.start   = 1'b1;
        bus.tz_mode = mode;
        bus.in_data = d;
        @(negedge clk); #1;
        bus.start   = 1'b0;
        bus.tz_mode = 1'($urandom_range(0, 1));
        bus.in_data = $urandom;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40; i++) begin
            if (exp_q.size() == 0) return;
            @(negedge clk); #1;
        end
        chk("timeout_idle", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    task automatic do_op(input logic mode, input logic [31:0] d);
        run_op(mode, d);
        wait_idle();
    endtask

    task automatic pin(input string name, input logic mode, input logic [31:0] d,
                       input logic [31:0] norm, input int z, input int lat);
        exp_t e;
        e = model(mode, d);
        chk({name, "_norm"}, 64'(e.norm), 64'(norm));
        chk({name, "_z"}, 64'(e.z), 64'(z));
        if (lat >= 0) chk({name, "_lat"}, 64'(e.lat), 64'(lat));
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rst_n       = 1'b0;
        bus.start   = 1'b0;
        bus.tz_mode = 1'b0;
        bus.in_data = '0;
        hold_norm   = '0;
        hold_z      = '0;
        hold_zf     = 1'b0;

        // Hand-computed pins of the model
        pin("pin1", 1'b0, 32'h8000_0000, 32'h8000_0000, 0, 3);
        pin("pin2", 1'b0, 32'h0001_0000, 32'h8000_0000, 15, 9);
        pin("pin3", 1'b1, 32'h0000_0A00, 32'h0000_0005, 9, -1);
        pin("pin4", 1'b0, 32'h0000_0000, 32'h0000_0000, 32, 10);
        pin("pin5", 1'b0, 32'h0000_0001, 32'h8000_0000, 31, 13);
        pin("pin6", 1'b1, 32'h8000_0000, 32'h0000_0001, 31, 13);

        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        // Directed vectors
        do_op(1'b0, 32'h8000_0000);
        do_op(1'b0, 32'h0001_0000);
        do_op(1'b1, 32'h0000_0A00);
        do_op(1'b0, 32'h0000_0000);
        do_op(1'b1, 32'h0000_0001);
        do_op(1'b1, 32'h0000_0000);

        // Start pulsed while busy must be ignored
        run_op(1'b0, 32'h0000_0001);
        repeat (2) @(negedge clk);
        #1;
        bus.start   = 1'b1;
        bus.tz_mode = 1'b1;
        bus.in_data = 32'hFFFF_FFFF;
        @(negedge clk); #1;
        bus.start   = 1'b0;
        wait_idle();

        // Reset during FINE aborts with no done pulse
        run_op(1'b0, 32'h0000_0001);
        for (int i = 0; i < 30 && dbg_state != 2'd2; i++) @(negedge clk);
        chk("reached_fine", 64'(dbg_state), 64'd2);
        @(posedge clk); #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        do_op(1'b1, 32'h0000_0A00);

        // Single set bit at every position, both modes
        for (int k = 0; k < 32; k++) begin
            do_op(1'b0, 32'h1 << k);
            do_op(1'b1, 32'h1 << k);
        end

        // Random words, biased toward long zero runs
        for (int k = 0; k < 40; k++) begin
            logic [31:0] d;
            d = $urandom >> $urandom_range(0, 31);
            if (k % 2 == 1) d = d << $urandom_range(0, 31);
            do_op(1'($urandom_range(0, 1)), d);
        end

        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
